// File: rtl/paddle_motion_controller.sv
// Per-player paddle sequencer: frame-rate accelerate/hold FSM, playfield clamp,
// and a registered per-scanline Y qualifier for the player draw checker.
module paddle_motion_controller #(
  parameter int V_CNT_WID    = 10,
  parameter int V_VISIBLE    = 480,
  parameter int PLAYER_HGT   = 64,
  parameter int START_Y      = 208,
  parameter int MAX_SPEED    = 8,
  parameter int ACCEL_FRAMES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frameTick,
  input  logic                 restart,
  input  logic                 btnUp,
  input  logic                 btnDown,
  input  logic [V_CNT_WID-1:0] drawY,
  output logic [V_CNT_WID-1:0] paddleY,
  output logic                 isValidY,
  output logic                 moving
);

  localparam int W       = V_CNT_WID + 1;
  localparam int SPD_WID = $clog2(MAX_SPEED + 1);
  localparam int CNT_WID = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

  localparam logic [V_CNT_WID-1:0] START_POS  = V_CNT_WID'(START_Y);
  localparam logic [V_CNT_WID-1:0] BOTTOM_POS = V_CNT_WID'(V_VISIBLE - PLAYER_HGT);
  localparam logic [W-1:0]         BOTTOM_W   = W'(V_VISIBLE - PLAYER_HGT);
  localparam logic [W-1:0]         HGT_W      = W'(PLAYER_HGT);
  localparam logic [SPD_WID-1:0]   SPEED_MAX  = SPD_WID'(MAX_SPEED);
  localparam logic [SPD_WID-1:0]   SPEED_ONE  = SPD_WID'(1);
  localparam logic [CNT_WID-1:0]   CNT_LAST   = CNT_WID'(ACCEL_FRAMES - 1);
  localparam logic [CNT_WID-1:0]   CNT_ZERO   = CNT_WID'(0);
  localparam logic [CNT_WID-1:0]   CNT_ONE    = CNT_WID'(1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MOVE_UP = 2'd1;
  localparam logic [1:0] ST_MOVE_DN = 2'd2;

  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_UP   = 2'd1;
  localparam logic [1:0] DIR_DN   = 2'd2;

  function automatic logic [1:0] decode_dir(input logic up, input logic dn);
    logic [1:0] dir;
    case ({up, dn})
      2'b10:   dir = DIR_UP;
      2'b01:   dir = DIR_DN;
      default: dir = DIR_NONE;
    endcase
    return dir;
  endfunction

  logic                 up_meta_q, up_sync_q, dn_meta_q, dn_sync_q;
  logic [1:0]           state_q, state_d;
  logic [SPD_WID-1:0]   speed_q, speed_d;
  logic [CNT_WID-1:0]   cnt_q, cnt_d;
  logic [V_CNT_WID-1:0] paddle_q, paddle_d;
  logic                 is_valid_q, is_valid_d;
  logic                 moving_q, moving_d;

  logic [1:0]           dir_s;
  logic [W-1:0]         paddle_w_s, speed_w_s, diff_w_s, sum_w_s, bot_w_s, draw_w_s;
  logic [V_CNT_WID-1:0] up_y_s, dn_y_s;
  logic [SPD_WID-1:0]   speed_acc_s;
  logic [CNT_WID-1:0]   cnt_acc_s;

  // Two-flop button synchronizers
  always_ff @(posedge clk) begin
    if (rst) begin
      up_meta_q <= 1'b0;
      up_sync_q <= 1'b0;
      dn_meta_q <= 1'b0;
      dn_sync_q <= 1'b0;
    end else begin
      up_meta_q <= btnUp;
      up_sync_q <= up_meta_q;
      dn_meta_q <= btnDown;
      dn_sync_q <= dn_meta_q;
    end
  end

  // Saturating move arithmetic at one extra bit; the borrow bit flags underflow
  always_comb begin
    dir_s      = decode_dir(up_sync_q, dn_sync_q);
    paddle_w_s = {1'b0, paddle_q};
    speed_w_s  = W'(speed_q);
    diff_w_s   = paddle_w_s - speed_w_s;
    sum_w_s    = paddle_w_s + speed_w_s;
    if (diff_w_s[W-1]) begin
      up_y_s = {V_CNT_WID{1'b0}};
    end else begin
      up_y_s = diff_w_s[V_CNT_WID-1:0];
    end
    if (sum_w_s > BOTTOM_W) begin
      dn_y_s = BOTTOM_POS;
    end else begin
      dn_y_s = sum_w_s[V_CNT_WID-1:0];
    end
    if (cnt_q == CNT_LAST) begin
      cnt_acc_s   = CNT_ZERO;
      speed_acc_s = (speed_q >= SPEED_MAX) ? SPEED_MAX : (speed_q + SPEED_ONE);
    end else begin
      cnt_acc_s   = cnt_q + CNT_ONE;
      speed_acc_s = speed_q;
    end
  end

  // Frame-rate state machine; restart overrides a coincident frameTick
  always_comb begin
    state_d  = state_q;
    speed_d  = speed_q;
    cnt_d    = cnt_q;
    paddle_d = paddle_q;
    if (restart) begin
      state_d  = ST_IDLE;
      speed_d  = SPEED_ONE;
      cnt_d    = CNT_ZERO;
      paddle_d = START_POS;
    end else if (frameTick) begin
      case (state_q)
        ST_IDLE: begin
          speed_d = SPEED_ONE;
          cnt_d   = CNT_ZERO;
          case (dir_s)
            DIR_UP:  state_d = ST_MOVE_UP;
            DIR_DN:  state_d = ST_MOVE_DN;
            default: state_d = ST_IDLE;
          endcase
        end
        ST_MOVE_UP, ST_MOVE_DN: begin
          if (dir_s == DIR_NONE) begin
            state_d = ST_IDLE;
            speed_d = SPEED_ONE;
            cnt_d   = CNT_ZERO;
          end else if ((dir_s == DIR_UP) == (state_q == ST_MOVE_UP)) begin
            paddle_d = (state_q == ST_MOVE_UP) ? up_y_s : dn_y_s;
            speed_d  = speed_acc_s;
            cnt_d    = cnt_acc_s;
          end else begin
            state_d = (dir_s == DIR_UP) ? ST_MOVE_UP : ST_MOVE_DN;
            speed_d = SPEED_ONE;
            cnt_d   = CNT_ZERO;
          end
        end
        default: begin
          state_d = ST_IDLE;
          speed_d = SPEED_ONE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end else begin
      state_d  = state_q;
      paddle_d = paddle_q;
    end
    moving_d = (state_d != ST_IDLE);
  end

  // Scanline qualifier against the paddle currently on screen
  always_comb begin
    draw_w_s   = {1'b0, drawY};
    bot_w_s    = paddle_w_s + HGT_W;
    is_valid_d = (draw_w_s >= paddle_w_s) && (draw_w_s < bot_w_s);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      speed_q    <= SPEED_ONE;
      cnt_q      <= CNT_ZERO;
      paddle_q   <= START_POS;
      is_valid_q <= 1'b0;
      moving_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      speed_q    <= speed_d;
      cnt_q      <= cnt_d;
      paddle_q   <= paddle_d;
      is_valid_q <= is_valid_d;
      moving_q   <= moving_d;
    end
  end

  assign paddleY  = paddle_q;
  assign isValidY = is_valid_q;
  assign moving   = moving_q;

endmodule

// File: tb/tb_paddle_motion_controller.sv
// Scoreboard bench for paddle_motion_controller: a move-count reference model
// predicts paddle position/moving per tick and the Y window per scanline.
module tb_paddle_motion_controller;

  localparam int VIS   = 480;
  localparam int HGT   = 64;
  localparam int START = 208;
  localparam int MAXS  = 8;
  localparam int ACC   = 4;
  localparam int BOT   = VIS - HGT;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frameTick = 1'b0;
  logic       restart = 1'b0;
  logic       btnUp = 1'b0;
  logic       btnDown = 1'b0;
  logic [9:0] drawY = 10'd0;
  logic [9:0] paddleY;
  logic       isValidY;
  logic       moving;

  typedef struct {
    int y;
    int mv;
  } exp_t;

  exp_t eq[$];
  int   vq[$];
  int   checks = 0;
  int   failures = 0;
  int   m_pos, m_mode, m_moves;
  bit   vchk = 1'b0;
  bit   evt_s = 1'b0;
  bit   vchk_s = 1'b0;

  paddle_motion_controller #(
    .V_CNT_WID(10), .V_VISIBLE(VIS), .PLAYER_HGT(HGT),
    .START_Y(START), .MAX_SPEED(MAXS), .ACCEL_FRAMES(ACC)
  ) dut (
    .clk(clk), .rst(rst), .frameTick(frameTick), .restart(restart),
    .btnUp(btnUp), .btnDown(btnDown), .drawY(drawY),
    .paddleY(paddleY), .isValidY(isValidY), .moving(moving)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: speed depends only on how many moves were made in the current hold.
  task automatic m_restart();
    m_pos = START; m_mode = 0; m_moves = 0;
  endtask

  task automatic m_tick(input bit up, input bit dn);
    int dir, spd;
    dir = (up && !dn) ? -1 : ((dn && !up) ? 1 : 0);
    if (dir == 0) begin
      m_mode = 0; m_moves = 0;
    end else if (m_mode != dir) begin
      m_mode = dir; m_moves = 0;
    end else begin
      spd = 1 + m_moves / ACC;
      if (spd > MAXS) spd = MAXS;
      m_pos = m_pos + dir * spd;
      if (m_pos < 0) m_pos = 0;
      if (m_pos > BOT) m_pos = BOT;
      m_moves++;
    end
  endtask

  // Monitor: note which edges carry an expected response
  always @(posedge clk) begin
    evt_s  <= frameTick | restart | rst;
    vchk_s <= vchk;
  end

  always @(negedge clk) begin
    exp_t e;
    int   v;
    if (evt_s) begin
      if (eq.size() == 0) begin
        chk("sb_state_underflow", 0, 1);
      end else begin
        e = eq.pop_front();
        chk("paddleY", int'(paddleY), e.y);
        chk("moving", int'(moving), e.mv);
      end
    end
    if (vchk_s) begin
      if (vq.size() == 0) begin
        chk("sb_valid_underflow", 0, 1);
      end else begin
        v = vq.pop_front();
        chk("isValidY", int'(isValidY), v);
      end
    end
  end

  task automatic do_tick(input bit up, input bit dn, input bit rs);
    @(negedge clk); btnUp = up; btnDown = dn;
    repeat (2) @(negedge clk);
    @(negedge clk);
    frameTick = 1'b1; restart = rs;
    if (rs) m_restart(); else m_tick(up, dn);
    eq.push_back('{y: m_pos, mv: (m_mode != 0) ? 1 : 0});
    @(negedge clk); frameTick = 1'b0; restart = 1'b0;
  endtask

  task automatic do_restart();
    @(negedge clk); restart = 1'b1;
    m_restart();
    eq.push_back('{y: m_pos, mv: 0});
    @(negedge clk); restart = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; vchk = 1'b1;
    m_restart();
    eq.push_back('{y: m_pos, mv: 0});
    vq.push_back(0);
    @(negedge clk); rst = 1'b0; vchk = 1'b0;
  endtask

  task automatic sweep(input int lo, input int hi);
    int a, b;
    a = (lo < 0) ? 0 : lo;
    b = (hi > 1023) ? 1023 : hi;
    for (int d = a; d <= b; d++) begin
      @(negedge clk); drawY = 10'(d); vchk = 1'b1;
      vq.push_back((d >= m_pos && d < m_pos + HGT) ? 1 : 0);
    end
    @(negedge clk); vchk = 1'b0;
  endtask

  initial begin
    int r, cur;
    m_restart();
    repeat (2) @(negedge clk);
    do_reset();
    sweep(START - 2, START + HGT + 1);

    repeat (3) do_tick(1'b1, 1'b0, 1'b0);
    chk("up3_pos", int'(paddleY), 206);
    chk("up3_moving", int'(moving), 1);

    do_restart();
    repeat (13) do_tick(1'b0, 1'b1, 1'b0);
    chk("accel_down_pos", int'(paddleY), 232);

    repeat (60) do_tick(1'b0, 1'b1, 1'b0);
    chk("bottom_sat", int'(paddleY), BOT);
    chk("bottom_moving", int'(moving), 1);
    sweep(BOT - 2, BOT + HGT + 1);

    repeat (70) do_tick(1'b1, 1'b0, 1'b0);
    chk("top_sat", int'(paddleY), 0);
    sweep(0, HGT + 1);

    do_tick(1'b1, 1'b1, 1'b0);
    chk("both_idle", int'(moving), 0);
    chk("both_pos", int'(paddleY), 0);

    do_restart();
    do_tick(1'b1, 1'b0, 1'b0);
    do_tick(1'b1, 1'b0, 1'b0);
    do_tick(1'b0, 1'b1, 1'b0);
    chk("reverse_nomove", int'(paddleY), 207);
    do_tick(1'b0, 1'b1, 1'b0);
    chk("reverse_step", int'(paddleY), 208);

    repeat (12) do_tick(1'b0, 1'b1, 1'b0);
    do_tick(1'b0, 1'b1, 1'b1);
    chk("restart_tick_pos", int'(paddleY), START);
    chk("restart_tick_moving", int'(moving), 0);

    repeat (7) do_tick(1'b1, 1'b0, 1'b0);
    do_reset();
    chk("rst_mid_pos", int'(paddleY), START);
    chk("rst_mid_moving", int'(moving), 0);
    chk("rst_mid_valid", int'(isValidY), 0);

    cur = 1;
    repeat (300) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        do_restart();
      end else if (r < 5) begin
        do_reset();
      end else if (r < 12) begin
        sweep(m_pos - 3 + int'($urandom_range(0, 2)), m_pos + HGT - 2 + int'($urandom_range(0, 3)));
      end else begin
        if ($urandom_range(0, 9) < 2) cur = int'($urandom_range(0, 3));
        do_tick(cur == 1 || cur == 3, cur == 2 || cur == 3, r < 15);
      end
    end

    repeat (3) @(negedge clk);
    chk("sb_drain", eq.size() + vq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/paddle_motion_controller.md
Name: paddle_motion_controller

Overview:
Per-player paddle sequencer for the Pong datapath. Samples the up/down buttons once per frame, runs an accelerate/hold state machine, clamps the paddle to the playfield, and publishes the paddle top Y. Each scanline it produces the registered isValidY qualifier that the player draw checker ANDs with its X test. One instance per player.

Parameters:
V_CNT_WID, 10, width of drawY and paddleY.
V_VISIBLE, 480, visible lines; the paddle must stay within 0..V_VISIBLE-1.
PLAYER_HGT, 64, paddle height in lines; must be less than V_VISIBLE.
START_Y, 208, paddle top after reset or restart.
MAX_SPEED, 8, maximum lines moved per frame; must be 1 or more.
ACCEL_FRAMES, 4, held frames per +1 speed step; must be 1 or more.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
frameTick  in  1  single-cycle pulse once per frame, asserted during vertical blank
restart  in  1  game restart request; level-sampled each cycle
btnUp  in  1  asynchronous button, active-high
btnDown  in  1  asynchronous button, active-high
drawY  in  V_CNT_WID  current beam line
paddleY  out  V_CNT_WID  paddle top line, changes only on frameTick
isValidY  out  1  drawY is in [paddleY, paddleY+PLAYER_HGT), registered
moving  out  1  high while state is not IDLE

Behaviour:
- Reset (rst=1 on a clock edge):
  - paddleY=START_Y, isValidY=0, moving=0.
  - State IDLE, speed=1, accel counter=0.
  - Synchronizer flops cleared.
  - Reset dominates all other inputs.
- Buttons: each passes through a 2-flop synchronizer. Only the synchronized value taken on the frameTick cycle is used.
- Direction decode at frameTick:
  - up only gives UP.
  - down only gives DOWN.
  - both or neither gives NONE.
- State machine, updated only on frameTick cycles:
  - IDLE: UP goes to MOVE_UP, DOWN goes to MOVE_DN, with speed=1 and counter=0. No position change on the entry tick.
  - MOVE_UP / MOVE_DN:
    - Same direction: apply a move of the current speed. Then counter++. When counter reaches ACCEL_FRAMES-1, reset counter to 0 and speed=min(speed+1, MAX_SPEED).
    - Opposite direction: go directly to the other MOVE state with speed=1 and counter=0. No move on that tick.
    - NONE: go to IDLE with speed=1.
- Move arithmetic uses V_CNT_WID+1 bits; no wrap-around is allowed.
  - Up: paddleY = (paddleY < speed) ? 0 : paddleY - speed.
  - Down: paddleY = min(paddleY + speed, V_VISIBLE - PLAYER_HGT).
  - At a limit, paddleY saturates and the state stays MOVE_*. moving stays 1.
- restart=1 (rst=0):
  - paddleY=START_Y, state IDLE, speed=1, counter=0 on the next edge, whether or not frameTick is high.
  - restart wins over frameTick in the same cycle.
- isValidY: registered every cycle (1-cycle latency) as (drawY >= paddleY) && (drawY < paddleY + PLAYER_HGT), compared at V_CNT_WID+1 bits. It uses the current paddleY register value.
- paddleY is stable for a whole visible frame, so the paddle does not tear.
- moving is a registered decode of the state.
- frameTick held for more than 1 cycle is a protocol violation; each high cycle counts as a tick.

Test Plan:
- Reset, then hold btnUp for 3 frameTicks (2 buttons synced before the first tick) -> paddleY 208 after the entry tick, then 207, then 206; moving=1.
- Hold btnDown for 1+12 ticks with ACCEL_FRAMES=4 -> per-tick steps 1,1,1,1,2,2,2,2,3,3,3,3 (sum 24); paddleY=232; speed holds at MAX_SPEED on longer holds.
- From paddleY=3, hold up with speed 2 -> paddleY 1, then 0, then stays 0. From the bottom, down saturates at 416 (480-64). No wrap values appear.
- btnUp and btnDown both high at a tick -> state IDLE, paddleY unchanged. Reversing from up to down -> no move on the reversal tick, then a step of 1 down.
- paddleY=100, sweep drawY 98..165 -> isValidY high exactly for drawY 100..163, 1 cycle after drawY is applied.
- Assert restart coincident with frameTick while moving at paddleY=300 -> next edge paddleY=208, moving=0. Also assert rst mid-acceleration -> all outputs return to reset values on the next edge.
